imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Responder end of the instruction fetch interface: holds program words and answers fetch requests over a valid/ready request/response handshake with a configurable wait-state latency.
- Also provides a word-write load port so a test bench or boot loader can place a program before and between fetches.
- Sits between the fetch unit (initiator) and the instruction storage array; replaces a purely combinational instruction lookup with a timed, back-pressurable one.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words stored; power of two, 16..4096.
- WAIT_STATES, 1, extra cycles between request acceptance and response valid; range 0..7.

Ports:
- clock  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  32  byte address of the requested instruction.
- rsp_valid  output  1  response word and error flags are valid.
- rsp_ready  input  1  initiator accepts the response.
- rsp_instr  output  32  fetched instruction word.
- rsp_err  output  2  bit0 = misaligned address, bit1 = address out of range.
- ld_en  input  1  write ld_data into storage at ld_addr.
- ld_addr  input  32  byte address for the load write; bits [1:0] are ignored.
- ld_data  input  32  word to store.
- ld_drop  output  1  one-cycle pulse: load request was not honoured.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (reset low, asynchronous): FSM to IDLE; req_ready=1, rsp_valid=0, rsp_instr=0, rsp_err=0, ld_drop=0, busy=0, wait counter=0. Storage contents are not cleared. Reset mid-transaction abandons the transaction with no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = !ld_en; load has priority over fetch.
  - ld_en=1 writes the word at the rising edge; FSM stays in IDLE.
  - req_valid && req_ready: latch req_addr and load the counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- WAIT: counter decrements each cycle; when it reaches 1, next state is RESP. req_ready=0.
- RESP:
  - rsp_valid=1; rsp_instr and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid && rsp_ready, next state is IDLE. No new request is accepted in the same cycle.
  - req_ready=0.
- Latency: a request accepted in cycle T gives rsp_valid high first in cycle T+1+WAIT_STATES. Stalls on rsp_ready extend the hold indefinitely.
- Address decode: word index = addr[31:2].
  - Misaligned (addr[1:0]!=0): rsp_err[0]=1 and rsp_instr=32'h00000013 (NOP).
  - Out of range (index >= DEPTH_WORDS): rsp_err[1]=1 and rsp_instr=NOP.
  - Both faults can be set together; rsp_instr is still NOP.
- Data capture: the storage read occurs on the transition into RESP. A load cannot occur after acceptance, because loads are only honoured in IDLE.
- Write-then-fetch: a load in cycle T followed by a fetch to the same address accepted in T+1 or later returns the new word.
- Loads:
  - ld_en while busy=1: write discarded, ld_drop=1 for exactly that cycle.
  - Out-of-range ld_addr: write discarded and ld_drop=1.
- rsp_instr and rsp_err retain their last values when rsp_valid=0.

Decomposition:
- Shared package imem_pkg contains:
  - NOP_INSTR = 32'h00000013;
  - state enum {IDLE, WAIT, RESP};
  - ERR_MISALIGN = 0 and ERR_RANGE = 1 bit indices;
  - a max-wait constant of 7.
- One sub-module imem_array: DEPTH_WORDS x 32 storage with one synchronous write port and one synchronous read port, no reset on contents.
- imem_responder holds the FSM, counter, address checks and handshake.

Test Plan:
- WAIT_STATES=1: load 0x00500093 at 0x0, fetch 0x0 with rsp_ready=1 -> req accepted at T, rsp_valid at T+2, rsp_instr=0x00500093, rsp_err=0, back to IDLE at T+3.
- WAIT_STATES=0: back-to-back fetches of 0x0, 0x4, 0x8 with rsp_ready tied 1 -> each response 1 cycle after acceptance; one request accepted every 2 cycles; words match the loaded values.
- Fetch 0x2 -> rsp_err=2'b01, rsp_instr=0x00000013. Fetch 0x400 with DEPTH_WORDS=256 -> rsp_err=2'b10, NOP. Fetch 0x402 -> rsp_err=2'b11.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_instr and rsp_err stable all 5 cycles; req_ready=0; assert ld_en during the hold -> ld_drop pulses and storage is unchanged on a later fetch.
- ld_en and req_valid together in IDLE -> req_ready=0, write performed; request accepted the next cycle and returns the newly loaded word.
- Drive reset low during WAIT -> outputs immediately at reset values, no response is produced. After reset release, a fetch of a previously loaded address returns the preserved word.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants, state encoding and address-check helpers for the
// instruction memory responder.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam int          ERR_MISALIGN = 0;
  localparam int          ERR_RANGE    = 1;
  localparam int          MAX_WAIT     = 7;
  localparam int          WAIT_CNT_W   = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  // Word index (addr[31:2]) fits in a storage of 2**idx_w words.
  function automatic logic word_in_range(input logic [31:0] addr, input int idx_w);
    return ((addr >> (idx_w + 2)) == 32'd0);
  endfunction

  // Fault flags for a fetch address: misalignment and index beyond the storage.
  function automatic logic [1:0] addr_faults(input logic [31:0] addr, input int idx_w);
    logic [1:0] faults;
    faults               = 2'b00;
    faults[ERR_MISALIGN] = (addr[1:0] != 2'b00);
    faults[ERR_RANGE]    = !word_in_range(addr, idx_w);
    return faults;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one synchronous
// read port. Contents are never reset so a loaded program survives reset.
module imem_array
  import imem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rd_data_r;

  // Word write; storage contents intentionally carry no reset
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  // Read register: updated only on a read strobe so the word holds afterwards
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_r <= 32'd0;
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_idx];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: accepts one request at a time over valid/ready, waits a
// fixed number of wait states, then presents the word (or NOP plus fault
// flags) until the initiator takes it. A load port writes words while idle.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [1:0]  rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_drop,
  output logic        busy
);

  localparam int                    IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  imem_state_e           state_r;
  imem_state_e           state_nxt_s;
  logic [WAIT_CNT_W-1:0] cnt_r;
  logic [31:0]           addr_r;
  logic [1:0]            err_r;
  logic                  ld_drop_r;
  logic                  req_ready_s;
  logic                  req_fire_s;
  logic                  capture_s;
  logic                  wr_en_s;
  logic [31:0]           rd_addr_s;
  logic [31:0]           rd_data_s;

  // Handshake and load decode; a pending load blocks fetch acceptance
  always_comb begin
    req_ready_s = 1'b0;
    wr_en_s     = 1'b0;
    rd_addr_s   = addr_r;
    if (state_r == IDLE) begin
      req_ready_s = !ld_en;
      wr_en_s     = ld_en && word_in_range(ld_addr, IDX_W);
      // With zero wait states the read happens at the acceptance edge
      rd_addr_s   = req_addr;
    end else begin
      req_ready_s = 1'b0;
      wr_en_s     = 1'b0;
      rd_addr_s   = addr_r;
    end
    req_fire_s = req_valid && req_ready_s;
  end

  // Next state, plus the strobe that reads storage on entry into RESP
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_fire_s) begin
          if (WAIT_STATES == 0) begin
            state_nxt_s = RESP;
            capture_s   = 1'b1;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r <= WAIT_CNT_W'(1)) begin
          state_nxt_s = RESP;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request address latch and wait-state countdown
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r  <= '0;
      addr_r <= 32'd0;
    end else if (req_fire_s) begin
      cnt_r  <= WAIT_LOAD;
      addr_r <= req_addr;
    end else if ((state_r == WAIT) && (cnt_r != '0)) begin
      cnt_r <= cnt_r - WAIT_CNT_W'(1);
    end
  end

  // Fault flags captured together with the storage read, held until next read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_r <= 2'b00;
    end else if (capture_s) begin
      err_r <= addr_faults(rd_addr_s, IDX_W);
    end
  end

  // Flags a refused load at the edge where the write would have happened
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_drop_r <= 1'b0;
    end else begin
      ld_drop_r <= ld_en && !wr_en_s;
    end
  end

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (wr_en_s),
    .wr_idx (ld_addr[IDX_W+1:2]),
    .wr_data(ld_data),
    .rd_en  (capture_s),
    .rd_idx (rd_addr_s[IDX_W+1:2]),
    .rd_data(rd_data_s)
  );

  assign req_ready = req_ready_s;
  assign rsp_valid = (state_r == RESP);
  assign busy      = (state_r != IDLE);
  assign rsp_err   = err_r;
  assign rsp_instr = (err_r != 2'b00) ? NOP_INSTR : rd_data_s;
  assign ld_drop   = ld_drop_r;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (0 and 1 wait states) driven by
// directed and random fetch/load traffic, checked against a word-array model.
module tb_imem_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_instr [2];
  logic [1:0]  rsp_err   [2];
  logic        ld_en     [2];
  logic [31:0] ld_addr   [2];
  logic [31:0] ld_data   [2];
  logic        ld_drop   [2];
  logic        busy      [2];

  logic [31:0] mem_m [2][DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr[0]),
    .rsp_err(rsp_err[0]), .ld_en(ld_en[0]), .ld_addr(ld_addr[0]),
    .ld_data(ld_data[0]), .ld_drop(ld_drop[0]), .busy(busy[0])
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr[1]),
    .rsp_err(rsp_err[1]), .ld_en(ld_en[1]), .ld_addr(ld_addr[1]),
    .ld_data(ld_data[1]), .ld_drop(ld_drop[1]), .busy(busy[1])
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Hard stop in case the run wedges
  initial begin
    #500000;
    $display("FAIL watchdog: run still going at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ws(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  // Reference answer for a fetch: {err, instr}
  function automatic logic [33:0] ref_rsp(input int i, input logic [31:0] addr);
    logic [1:0]  err;
    logic [31:0] w;
    err[0] = (addr % 4) != 0;
    err[1] = (addr / 4) >= DEPTH;
    if (err != 2'b00) w = NOP;
    else              w = mem_m[i][addr / 4];
    return {err, w};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int i, input logic [31:0] addr, input logic [31:0] data);
    logic exp_drop;
    exp_drop = (addr / 4) >= DEPTH;
    ld_en[i] = 1'b1; ld_addr[i] = addr; ld_data[i] = data;
    #1;
    check_eq("ld_req_ready", req_ready[i], 32'd0);
    cyc();
    ld_en[i] = 1'b0;
    check_eq("ld_drop", ld_drop[i], exp_drop);
    if (!exp_drop) mem_m[i][addr / 4] = data;
  endtask

  // One fetch: optional stall of the response, optional load during the stall
  task automatic fetch(input int i, input logic [31:0] addr, input int stall, input bit ld_mid);
    logic [33:0] e;
    int          lat;
    e = ref_rsp(i, addr);
    req_valid[i] = 1'b1; req_addr[i] = addr;
    #1;
    check_eq("req_ready_idle", req_ready[i], 32'd1);
    cyc();
    req_valid[i] = 1'b0;
    lat = 1;
    while (!rsp_valid[i] && lat < 20) begin
      cyc();
      lat++;
    end
    check_eq("latency", lat, 1 + ws(i));
    check_eq("rsp_instr", rsp_instr[i], e[31:0]);
    check_eq("rsp_err", rsp_err[i], {30'd0, e[33:32]});
    check_eq("busy_resp", busy[i], 32'd1);
    check_eq("req_ready_resp", req_ready[i], 32'd0);
    for (int s = 0; s < stall; s++) begin
      if (ld_mid && s == 1) begin
        ld_en[i] = 1'b1; ld_addr[i] = 32'h0; ld_data[i] = ~mem_m[i][0];
      end
      cyc();
      ld_en[i] = 1'b0;
      check_eq("hold_ld_drop", ld_drop[i], (ld_mid && s == 1) ? 32'd1 : 32'd0);
      check_eq("hold_valid", rsp_valid[i], 32'd1);
      check_eq("hold_instr", rsp_instr[i], e[31:0]);
      check_eq("hold_err", rsp_err[i], {30'd0, e[33:32]});
      check_eq("hold_req_ready", req_ready[i], 32'd0);
    end
    rsp_ready[i] = 1'b1;
    cyc();
    rsp_ready[i] = 1'b0;
    check_eq("after_valid", rsp_valid[i], 32'd0);
    check_eq("after_busy", busy[i], 32'd0);
    check_eq("after_instr", rsp_instr[i], e[31:0]);
    check_eq("after_err", rsp_err[i], {30'd0, e[33:32]});
  endtask

  // Load and fetch presented together: load wins, fetch accepted next cycle
  task automatic ld_and_fetch(input int i, input logic [31:0] addr, input logic [31:0] data);
    ld_en[i] = 1'b1; ld_addr[i] = addr; ld_data[i] = data;
    req_valid[i] = 1'b1; req_addr[i] = addr;
    #1;
    check_eq("ldreq_ready", req_ready[i], 32'd0);
    cyc();
    ld_en[i] = 1'b0;
    mem_m[i][addr / 4] = data;
    check_eq("ldreq_drop", ld_drop[i], 32'd0);
    fetch(i, addr, 0, 1'b0);
  endtask

  task automatic check_reset_outputs(input int i);
    check_eq("rst_req_ready", req_ready[i], 32'd1);
    check_eq("rst_rsp_valid", rsp_valid[i], 32'd0);
    check_eq("rst_rsp_instr", rsp_instr[i], 32'd0);
    check_eq("rst_rsp_err", rsp_err[i], 32'd0);
    check_eq("rst_ld_drop", ld_drop[i], 32'd0);
    check_eq("rst_busy", busy[i], 32'd0);
  endtask

  initial begin
    logic [31:0] s_addr [3];
    logic [33:0] e;
    logic [31:0] a;
    int          k;
    int          sel;

    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = 32'd0; rsp_ready[i] = 1'b0;
      ld_en[i] = 1'b0; ld_addr[i] = 32'd0; ld_data[i] = 32'd0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) check_reset_outputs(i);
    reset = 1'b1;
    cyc();
    for (int i = 0; i < 2; i++) check_reset_outputs(i);

    // First fetch with one wait state
    load(1, 32'h0, 32'h0050_0093);
    fetch(1, 32'h0, 0, 1'b0);

    // Preload words 0..31 and the last word
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 32; w++) load(i, w * 4, $urandom);
      load(i, 32'h3FC, $urandom);
    end

    // Back-to-back fetches, zero wait states, response always accepted
    s_addr[0] = 32'h0; s_addr[1] = 32'h4; s_addr[2] = 32'h8;
    rsp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = s_addr[0]; k = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c % 2 == 0) begin
        check_eq("b2b_req_ready", req_ready[0], 32'd1);
        check_eq("b2b_rsp_valid_lo", rsp_valid[0], 32'd0);
      end else begin
        e = ref_rsp(0, s_addr[k]);
        check_eq("b2b_req_ready_lo", req_ready[0], 32'd0);
        check_eq("b2b_rsp_valid", rsp_valid[0], 32'd1);
        check_eq("b2b_instr", rsp_instr[0], e[31:0]);
        check_eq("b2b_err", rsp_err[0], {30'd0, e[33:32]});
        k++;
        if (k < 3) req_addr[0] = s_addr[k];
      end
      cyc();
    end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b0;
    #1;
    check_eq("b2b_idle", busy[0], 32'd0);

    // Address faults and the last valid word
    for (int i = 0; i < 2; i++) begin
      fetch(i, 32'h2, 0, 1'b0);
      fetch(i, 32'h400, 0, 1'b0);
      fetch(i, 32'h402, 1, 1'b0);
      fetch(i, 32'h3FC, 0, 1'b0);
      // Out-of-range load must not alias onto word 0
      load(i, 32'h400, ~mem_m[i][0]);
      fetch(i, 32'h0, 0, 1'b0);
      // Long stall with a refused load in the middle
      fetch(i, 32'h4, 5, 1'b1);
      fetch(i, 32'h0, 0, 1'b0);
      ld_and_fetch(i, 32'h40, $urandom);
    end

    // Reset while waiting: transaction abandoned, storage kept
    req_valid[1] = 1'b1; req_addr[1] = 32'h8;
    cyc();
    req_valid[1] = 1'b0;
    check_eq("wait_busy", busy[1], 32'd1);
    check_eq("wait_rsp_valid", rsp_valid[1], 32'd0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) check_reset_outputs(i);
    cyc();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      check_eq("post_rst_no_rsp", rsp_valid[1], 32'd0);
    end
    fetch(1, 32'h8, 0, 1'b0);
    fetch(0, 32'h8, 0, 1'b0);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 2; i++) begin
        sel = $urandom_range(0, 12);
        if (sel < 3) begin
          a = $urandom_range(0, 31) * 4;
          if (sel == 2) a = a | 32'h400;
          load(i, a, $urandom);
        end else begin
          if (sel < 8)       a = $urandom_range(0, 31) * 4;
          else if (sel == 8) a = 32'h3FC;
          else if (sel == 9) a = $urandom_range(0, 31) * 4 + $urandom_range(1, 3);
          else if (sel == 10) a = 32'h400 + $urandom_range(0, 255) * 4;
          else               a = $urandom | 32'h8000_0000;
          k = $urandom_range(0, 3);
          fetch(i, a, k, (k >= 2) && ($urandom_range(0, 1) == 1));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
